// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, reset PC and NOP encoding for the MIPS pipeline
package mips_pkg;
    localparam int          DEF_PC_W     = 32;
    localparam int          DEF_INSTR_W  = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;
    localparam int          CNT_W        = 16;
endpackage

// File: rtl/pc_if_stage_if.sv
// rtl/pc_if_stage_if.sv - fetch bus: PC out to imem/incrementer, instruction and PC+1 back
interface pc_if_stage_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus_in;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output pc, input pc_plus_in, input imem_rdata);
    modport slave  (input pc, output pc_plus_in, output imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with rst > flush > stall > load priority
module if_id_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_plus_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_plus_o,
    output logic               valid_o
);
    import mips_pkg::*;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_plus_q, pc_plus_d;
    logic               valid_q, valid_d;

    // Flush beats stall so a wrong-path fetch is never held in place.
    always_comb begin
        instr_d   = instr_q;
        pc_plus_d = pc_plus_q;
        valid_d   = valid_q;
        if (flush) begin
            instr_d   = INSTR_W'(INSTR_NOP);
            pc_plus_d = '0;
            valid_d   = 1'b0;
        end else if (!stall) begin
            instr_d   = instr_i;
            pc_plus_d = pc_plus_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= INSTR_W'(INSTR_NOP);
            pc_plus_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_plus_q <= pc_plus_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_plus_o = pc_plus_q;
    assign valid_o   = valid_q;
endmodule

// File: rtl/pc_if_stage.sv
// rtl/pc_if_stage.sv - fetch-stage PC register, next-PC select, redirect counter and IF/ID
module pc_if_stage
    import mips_pkg::*;
#(
    parameter int          PC_W     = DEF_PC_W,
    parameter int          INSTR_W  = DEF_INSTR_W,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 br_taken,
    input  logic [PC_W-1:0]      br_target,
    input  logic                 jump,
    input  logic [PC_W-1:0]      jump_target,
    pc_if_stage_if.master        fbus,
    output logic [INSTR_W-1:0]   if_id_instr,
    output logic [PC_W-1:0]      if_id_pc_plus,
    output logic                 if_id_valid,
    output logic [CNT_W-1:0]     redirect_cnt
);
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redirect;

    assign redirect = jump | br_taken;

    // A resolved control transfer outranks a stall so it is never dropped.
    always_comb begin
        pc_d = fbus.pc_plus_in;
        if (jump) begin
            pc_d = jump_target;
        end else if (br_taken) begin
            pc_d = br_target;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= PC_W'(RESET_PC);
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign fbus.pc      = pc_q;
    assign redirect_cnt = cnt_q;

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .instr_i   (fbus.imem_rdata),
        .pc_plus_i (fbus.pc_plus_in),
        .instr_o   (if_id_instr),
        .pc_plus_o (if_id_pc_plus),
        .valid_o   (if_id_valid)
    );
endmodule
